// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and legality helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Stores only have signed encodings; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = ~lo[0];
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a bus read word for loads.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_mem_rdata;
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory interface: req/gnt/rvalid bus, byte strobes, load extension.
// Optional access timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;

    logic        w_ok;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_timeout;

    // DONE is the single cycle the core is released, so the same instruction never re-issues.
    assign stall = req_valid & (r_state != S_DONE);

    assign w_ok = f3_legal(req_we, funct3) & addr_aligned(funct3, addr[1:0]);

    always_comb begin
        case (funct3)
            F3_B: begin
                w_strb  = STRB_B << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                w_strb  = STRB_H << addr[1:0];
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_strb  = STRB_W;
                w_wdata = wdata;
            end
        endcase
    end

    load_align u_align (
        .i_mem_rdata (mem_rdata),
        .i_addr_lo   (r_addr_lo),
        .i_funct3    (r_funct3),
        .o_data      (w_load)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state == S_IDLE)
            r_cnt <= '0;
        else if (r_state == S_REQ || r_state == S_WAIT)
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires on the last allowed REQ/WAIT cycle so the abort lands exactly at the limit.
    assign w_timeout = (r_state == S_REQ || r_state == S_WAIT) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr_lo   <= 2'd0;
            r_funct3    <= 3'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wstrb   <= 4'd0;
            mem_wdata   <= 32'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr_lo <= addr[1:0];
                        r_funct3  <= funct3;
                        if (w_ok) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wstrb <= req_we ? w_strb : 4'd0;
                            mem_wdata <= req_we ? w_wdata : 32'd0;
                            r_state   <= S_REQ;
                        end else begin
                            rdata       <= 32'd0;
                            rdata_valid <= 1'b1;
                            err         <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            rdata       <= 32'd0;
                            rdata_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_timeout) begin
                        mem_req     <= 1'b0;
                        rdata       <= 32'd0;
                        rdata_valid <= 1'b1;
                        err         <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        rdata       <= w_load;
                        rdata_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        rdata       <= 32'd0;
                        rdata_valid <= 1'b1;
                        err         <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit; the timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rdata_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdata_valid rdata=%h err=%b", rdata, err);
            end else begin
                mon_e = sb.pop_front();
                if (err !== mon_e.err) begin
                    errors++;
                    $display("FAIL sb_err got=%b exp=%b", err, mon_e.err);
                end
                if (mon_e.chk_data && rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL sb_rdata got=%h exp=%h", rdata, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    // Drives one access and plays the bus side; returns what it observed, checks nothing.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] word, output int stalls, output int reqs,
                         output logic [31:0] a0, output logic [3:0] s0,
                         output logic [31:0] d0, output logic w0, output logic stable);
        int  wcnt;
        bit  done;
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        stalls = 0; reqs = 0; a0 = '0; s0 = '0; d0 = '0; w0 = 1'b0; stable = 1'b1;
        wcnt = -1; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++; else done = 1'b1;
            if (mem_req) begin
                if (reqs == 0) begin
                    a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata; w0 = mem_we;
                end else if (mem_addr !== a0 || mem_wstrb !== s0 || mem_wdata !== d0 || mem_we !== w0) begin
                    stable = 1'b0;
                end
                if (reqs == gnt_dly) begin
                    mem_gnt = 1'b1;
                    if (!we) wcnt = 0;
                end
                reqs++;
            end else if (wcnt >= 0) begin
                if (wcnt == rv_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = word; wcnt = -1;
                end else begin
                    wcnt++;
                end
            end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_wstrb, rdata_valid, err, stall} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_we, mem_wstrb, rdata_valid, err, stall});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, rdata);
        end
        req_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=1", stall);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b1});
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 3 || rq != 1) begin
            errors++;
            $display("FAIL lw_timing stalls=%0d reqs=%0d exp=3/1", st, rq);
        end
        checks++;
        if (a0 !== 32'h100 || s0 !== 4'd0 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus addr=%h strb=%b we=%b exp=100/0000/0", a0, s0, w0);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b100, 3'b000};
        logic [31:0] as  [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
        logic [31:0] ws  [8] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                                 32'h80FF0000, 32'h12348001, 32'h00007F00, 32'hAA55AA7F};
        logic [31:0] ex  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'hFFFF80FF,
                                 32'h000080FF, 32'hFFFF8001, 32'h0000007F, 32'h0000007F};
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{1'b0, ex[i], 1'b1});
            issue(1'b0, f3s[i], as[i], 32'h0, i % 2, i % 3, ws[i], st, rq, a0, s0, d0, w0, stb);
            checks++;
            if (st != 3 + (i % 2) + (i % 3) || a0 !== {as[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_ext[%0d] stalls=%0d addr=%h exp=%0d/%h", i, st, a0,
                         3 + (i % 2) + (i % 3), {as[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] as  [5] = '{32'h202, 32'h201, 32'h203, 32'h204, 32'h200};
        logic [31:0] wds [5] = '{32'h1234ABCD, 32'h556677CD, 32'h00000011, 32'hCAFEF00D, 32'h12345678};
        int          gd  [5] = '{3, 0, 2, 1, 0};
        logic [3:0]  es  [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        logic [31:0] ed  [5] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h11111111, 32'hCAFEF00D, 32'h56785678};
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{1'b0, 32'h0, 1'b0});
            issue(1'b1, f3s[i], as[i], wds[i], gd[i], 0, 32'h0, st, rq, a0, s0, d0, w0, stb);
            checks++;
            if (st != 2 + gd[i] || rq != 1 + gd[i] || stb !== 1'b1) begin
                errors++;
                $display("FAIL store_timing[%0d] stalls=%0d reqs=%0d stable=%b exp=%0d/%0d/1",
                         i, st, rq, stb, 2 + gd[i], 1 + gd[i]);
            end
            checks++;
            if (a0 !== {as[i][31:2], 2'b00} || s0 !== es[i] || d0 !== ed[i] || w0 !== 1'b1) begin
                errors++;
                $display("FAIL store_bus[%0d] addr=%h strb=%b wdata=%h we=%b exp=%h/%b/%h/1",
                         i, a0, s0, d0, w0, {as[i][31:2], 2'b00}, es[i], ed[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        wes [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [7] = '{3'b010, 3'b011, 3'b001, 3'b010, 3'b001, 3'b100, 3'b110};
        logic [31:0] as  [7] = '{32'h101, 32'h100, 32'h103, 32'h102, 32'h201, 32'h200, 32'h100};
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{1'b1, 32'h0, 1'b1});
            issue(wes[i], f3s[i], as[i], 32'hFFFFFFFF, 0, 0, 32'h0, st, rq, a0, s0, d0, w0, stb);
            checks++;
            if (st != 1 || rq != 0) begin
                errors++;
                $display("FAIL err_access[%0d] stalls=%0d reqs=%0d exp=1/0", i, st, rq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        sb.push_back('{1'b0, 32'h01234567, 1'b1});
        issue(1'b0, 3'b010, 32'h500, 32'h0, 0, 0, 32'h01234567, st, rq, a0, s0, d0, w0, stb);
        sb.push_back('{1'b0, 32'h0, 1'b0});
        issue(1'b1, 3'b010, 32'h504, 32'h89ABCDEF, 0, 0, 32'h0, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 2 || a0 !== 32'h504) begin
            errors++;
            $display("FAIL b2b_store stalls=%0d addr=%h exp=2/504", st, a0);
        end
        sb.push_back('{1'b0, 32'h000000F0, 1'b1});
        issue(1'b0, 3'b100, 32'h509, 32'h0, 0, 0, 32'h0000F000, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 3 || a0 !== 32'h508) begin
            errors++;
            $display("FAIL b2b_load stalls=%0d addr=%h exp=3/508", st, a0);
        end
    endtask

    task automatic test_reset_mid();
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        mem_gnt = mem_req;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid req=%b valid=%b stall=%b rdata=%h exp=0/0/0/0",
                     mem_req, rdata_valid, stall, rdata);
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_rvalid req=%b valid=%b exp=0/0", mem_req, rdata_valid);
        end
        @(posedge clk); #1;
        sb.push_back('{1'b0, 32'hFFFFA5A5, 1'b1});
        issue(1'b0, 3'b001, 32'h302, 32'h0, 0, 0, 32'hA5A50000, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 3) begin
            errors++;
            $display("FAIL after_reset stalls=%0d exp=3", st);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int st, rq; logic [31:0] a0, d0; logic [3:0] s0; logic w0, stb;
        sb.push_back('{1'b1, 32'h0, 1'b1});
        issue(1'b0, 3'b010, 32'h400, 32'h0, 1000, 0, 32'h0, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 5 || rq != 4) begin
            errors++;
            $display("FAIL timeout_req stalls=%0d reqs=%0d exp=5/4", st, rq);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late req=%b valid=%b exp=0/0", mem_req, rdata_valid);
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        sb.push_back('{1'b1, 32'h0, 1'b1});
        issue(1'b0, 3'b010, 32'h404, 32'h0, 0, 1000, 32'h0, st, rq, a0, s0, d0, w0, stb);
        checks++;
        if (st != 5 || rq != 1) begin
            errors++;
            $display("FAIL timeout_wait stalls=%0d reqs=%0d exp=5/1", st, rq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory interface directly downstream of the core datapath.
- Takes the datapath's memory address, store data and funct3, and drives a request/grant/rvalid data-memory bus with word-aligned address and byte strobes.
- Returns aligned, sign/zero-extended load data as the datapath's ReadData.
- Holds the core with `stall` until the access completes.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in REQ+WAIT before an access is aborted. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  current instruction is a load/store; held until stall=0
- req_we  input  1  1=store, 0=load
- funct3  input  3  Instr[14:12]; selects width/signedness
- addr  input  32  byte address (datapath Mem_WrAddr)
- wdata  input  32  store data (datapath Mem_WrData)
- stall  output  1  freeze PC/regfile write this cycle
- rdata  output  32  extended load result (datapath ReadData)
- rdata_valid  output  1  one-cycle pulse, result/completion cycle
- err  output  1  one-cycle pulse with rdata_valid on misaligned, illegal-funct3 or timed-out access
- mem_req  output  1  bus request
- mem_we  output  1  bus write enable
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wstrb  output  4  byte strobes (all 0 for loads)
- mem_wdata  output  32  lane-replicated store data
- mem_gnt  input  1  bus accepts request this cycle
- mem_rvalid  input  1  read data valid; earliest one cycle after gnt
- mem_rdata  input  32  read word

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, rdata=0, rdata_valid=0, err=0.
- `stall` is combinational: `stall = req_valid & (state != DONE)`. The same equation applies during reset.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On `req_valid`, latch addr, funct3, we and wdata.
  - Legal and aligned → REQ.
  - Illegal or misaligned → DONE with err=1 and no bus access.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wstrb and mem_wdata are stable until gnt.
  - gnt on a store → DONE. Store completes on grant.
  - gnt on a load → WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, extract the lane from mem_rdata using latched addr[1:0], sign- or zero-extend per funct3, register into rdata, → DONE.
- DONE:
  - rdata_valid=1 and stall=0 for exactly one cycle, then → IDLE unconditionally. This prevents re-issue of the same instruction.
- Store encoding:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: wstrb=4'b1111, wdata=wdata.
- Load extension:
  - LB/LH replicate the top bit of the selected byte/half.
  - LBU/LHU zero-fill.
- On err, rdata=0.
- Reset mid-access:
  - Returns to IDLE at the edge; mem_req=0 the next cycle.
  - A stale mem_rvalid arriving in IDLE is ignored.
- Minimum latencies:
  - Store with immediate gnt: 2 stall cycles, completing in the 3rd cycle.
  - Load with gnt then rvalid next cycle: 3 stall cycles.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+-bit counter (width $clog2(TIMEOUT_CYCLES+1)) clears on IDLE→REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: → DONE with err=1, rdata=0, mem_req dropped.
  - A late rvalid arriving afterwards is ignored.
- Not defined: no counter exists, and REQ/WAIT wait indefinitely.

Decomposition:
- Package `lsu_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state enum, 2 bits.
  - Strobe base constants.
- One combinational sub-module, `load_align`: inputs mem_rdata, addr[1:0], funct3; output the extended 32-bit value. It is reused for formal checks.

Test Plan:
- LW addr=0x100, gnt at cycle 1, rvalid at cycle 2 with mem_rdata=0xDEADBEEF → mem_addr=0x100, rdata=0xDEADBEEF, rdata_valid in cycle 3, stall high for cycles 0-2.
- LB addr=0x103 with mem_rdata=0x80FF_0000, then LBU at the same address → rdata=0xFFFFFF80, then 0x00000080.
- SH addr=0x202 with wdata=0x1234ABCD and gnt delayed 3 cycles → mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200. All stay stable until gnt; DONE follows the next cycle.
- LW addr=0x101 → no mem_req, err=1 and rdata_valid=1 in cycle 1, rdata=0. funct3=011 gives the same response.
- Reset asserted in WAIT, then rvalid next cycle → state IDLE, no rdata_valid, mem_req=0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted → err and rdata_valid pulse in cycle 5, mem_req low afterwards.
